// File: rtl/operand_stack_pkg.sv
// operand_stack_pkg
// Shared definitions for the operand stack and the CPU control FSM that
// drives it: default geometry and the stack operation encodings, which are
// formed as {push, pop}.
package operand_stack_pkg;

    localparam int STACK_DATA_W = 8;
    localparam int STACK_DEPTH  = 16;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        return stack_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/operand_stack_strobe_edge_detect.sv
// strobe_edge_detect
// Rising-edge detector for a request strobe sampled in the clk domain.
// The history register presets to 1, so a strobe that is already high when
// reset releases does not fire until it drops and rises again.
// Ports:
//   clk_i     system clock
//   reset_i   synchronous, active-high reset
//   strobe_i  request strobe (level)
//   rise_o    one-cycle pulse on the strobe's rising edge
module strobe_edge_detect (
    input  logic clk_i,
    input  logic reset_i,
    input  logic strobe_i,
    output logic rise_o
);

    logic strb_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            strb_q <= 1'b1;
        end else begin
            strb_q <= strobe_i;
        end
    end

    assign rise_o = strobe_i & ~strb_q;

endmodule

// File: rtl/operand_stack.sv
// operand_stack
// LIFO operand stack for the stack-machine datapath. One operation fires per
// rising edge of stack_clk; {push,pop} selects PUSH, POP, REPLACE or no-op.
// The top of stack is held in a dedicated register so the read path is
// never longer than one cycle.
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   stack_clk        operation strobe (level, edge-detected here)
//   push, pop        operation qualifiers, sampled in the trigger cycle
//   data_to_push     value written on PUSH/REPLACE
//   clear_err        clears sticky overflow/underflow
//   data_from_stack  registered top of stack, 0 when empty
//   sp               entry count 0..DEPTH
//   empty, full      decoded from sp
//   overflow         sticky: push attempted while full
//   underflow        sticky: pop attempted while empty
module operand_stack
    import operand_stack_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter int DEPTH  = STACK_DEPTH,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stack_clk,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_to_push,
    input  logic              clear_err,
    output logic [DATA_W-1:0] data_from_stack,
    output logic [PTR_W:0]    sp,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int SP_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [SP_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0] tos_q, tos_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              we;
    logic [PTR_W-1:0]  waddr;
    logic [PTR_W-1:0]  sp_lo;
    logic              trig;
    logic              is_empty, is_full;
    stack_op_e         op;

    strobe_edge_detect u_strb (
        .clk_i    (clk),
        .reset_i  (reset),
        .strobe_i (stack_clk),
        .rise_o   (trig)
    );

    assign op       = decode_op(push, pop);
    assign sp_lo    = sp_q[PTR_W-1:0];
    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_W'(DEPTH));

    always_comb begin
        sp_d  = sp_q;
        tos_d = tos_q;
        // A flag set by this cycle's trigger overrides clear_err below.
        ovf_d = ovf_q & ~clear_err;
        unf_d = unf_q & ~clear_err;
        we    = 1'b0;
        waddr = sp_lo;
        if (trig) begin
            unique case (op)
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        we    = 1'b1;
                        waddr = sp_lo;
                        sp_d  = sp_q + SP_W'(1);
                        tos_d = data_to_push;
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        unf_d = 1'b1;
                    end else if (sp_q == SP_W'(1)) begin
                        sp_d  = '0;
                        tos_d = '0;
                    end else begin
                        // New top is the entry below the current top.
                        sp_d  = sp_q - SP_W'(1);
                        tos_d = mem[sp_lo - PTR_W'(2)];
                    end
                end
                OP_REPLACE: begin
                    we    = 1'b1;
                    tos_d = data_to_push;
                    if (is_empty) begin
                        waddr = sp_lo;
                        sp_d  = sp_q + SP_W'(1);
                    end else begin
                        waddr = sp_lo - PTR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q  <= '0;
            tos_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            tos_q <= tos_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Storage has no reset; a write is suppressed when reset discards the op.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            mem[waddr] <= data_to_push;
        end
    end

    assign data_from_stack = tos_q;
    assign sp              = sp_q;
    assign empty           = is_empty;
    assign full            = is_full;
    assign overflow        = ovf_q;
    assign underflow       = unf_q;

endmodule

// File: tb/tb_operand_stack.sv
module tb_operand_stack;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       stack_clk = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_to_push = 8'h00;
    logic       clear_err = 1'b0;
    logic [7:0] data_from_stack;
    logic [4:0] sp;
    logic       empty, full, overflow, underflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    operand_stack #(.DATA_W(8), .DEPTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .stack_clk       (stack_clk),
        .push            (push),
        .pop             (pop),
        .data_to_push    (data_to_push),
        .clear_err       (clear_err),
        .data_from_stack (data_from_stack),
        .sp              (sp),
        .empty           (empty),
        .full            (full),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        stack_clk = 1'b0; push = 1'b0; pop = 1'b0; clear_err = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // One strobe held for one clk edge, then low for one edge.
    task automatic op(input logic p, input logic q, input logic [7:0] d);
        @(negedge clk);
        push = p; pop = q; data_to_push = d; stack_clk = 1'b1;
        @(negedge clk);
        stack_clk = 1'b0; push = 1'b0; pop = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset(3);
        total_cnt++; if (sp !== 5'd0) $display("FAIL reset_sp got %0d exp 0", sp); else pass_cnt++;
        total_cnt++; if (data_from_stack !== 8'h00) $display("FAIL reset_tos got %h exp 00", data_from_stack); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_empty_full got %b%b exp 10", empty, full); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); else pass_cnt++;
    endtask

    task automatic test_push();
        logic [7:0] vals [3];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            push = 1'b1; pop = 1'b0; data_to_push = vals[i]; stack_clk = 1'b1;
            @(negedge clk);
            total_cnt++; if (sp !== 5'(i + 1) || data_from_stack !== vals[i])
                $display("FAIL push_latency[%0d] got sp=%0d tos=%h exp sp=%0d tos=%h", i, sp, data_from_stack, i + 1, vals[i]);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++; if (sp !== 5'(i + 1))
                $display("FAIL push_no_double[%0d] got sp=%0d exp %0d", i, sp, i + 1);
            else pass_cnt++;
            stack_clk = 1'b0; push = 1'b0;
            @(negedge clk);
        end
        total_cnt++; if (empty !== 1'b0) $display("FAIL push_not_empty got %b exp 0", empty); else pass_cnt++;
    endtask

    task automatic test_pop();
        op(1'b0, 1'b1, 8'hFF);
        total_cnt++; if (sp !== 5'd2 || data_from_stack !== 8'h22) $display("FAIL pop1 got sp=%0d tos=%h exp sp=2 tos=22", sp, data_from_stack); else pass_cnt++;
        op(1'b0, 1'b1, 8'hFF);
        total_cnt++; if (sp !== 5'd1 || data_from_stack !== 8'h11) $display("FAIL pop2 got sp=%0d tos=%h exp sp=1 tos=11", sp, data_from_stack); else pass_cnt++;
        op(1'b0, 1'b1, 8'hFF);
        total_cnt++; if (sp !== 5'd0 || data_from_stack !== 8'h00 || empty !== 1'b1)
            $display("FAIL pop_last got sp=%0d tos=%h empty=%b exp sp=0 tos=00 empty=1", sp, data_from_stack, empty); else pass_cnt++;
        total_cnt++; if (underflow !== 1'b0) $display("FAIL pop_last_no_unf got %b exp 0", underflow); else pass_cnt++;
        op(1'b0, 1'b1, 8'hFF);
        total_cnt++; if (underflow !== 1'b1 || sp !== 5'd0) $display("FAIL pop_underflow got unf=%b sp=%0d exp unf=1 sp=0", underflow, sp); else pass_cnt++;
        @(negedge clk); clear_err = 1'b1;
        @(negedge clk); clear_err = 1'b0;
        total_cnt++; if (underflow !== 1'b0) $display("FAIL unf_clear got %b exp 0", underflow); else pass_cnt++;
    endtask

    task automatic test_full();
        do_reset(2);
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 8'(i));
        total_cnt++; if (sp !== 5'd16 || full !== 1'b1 || data_from_stack !== 8'h0F)
            $display("FAIL fill got sp=%0d full=%b tos=%h exp sp=16 full=1 tos=0f", sp, full, data_from_stack); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL fill_no_ovf got %b exp 0", overflow); else pass_cnt++;
        op(1'b1, 1'b0, 8'hAA);
        total_cnt++; if (overflow !== 1'b1 || sp !== 5'd16 || data_from_stack !== 8'h0F)
            $display("FAIL overflow got ovf=%b sp=%0d tos=%h exp ovf=1 sp=16 tos=0f", overflow, sp, data_from_stack); else pass_cnt++;
        // Clear and a new overflow in the same cycle: the set wins.
        @(negedge clk);
        push = 1'b1; data_to_push = 8'hAA; stack_clk = 1'b1; clear_err = 1'b1;
        @(negedge clk);
        stack_clk = 1'b0; push = 1'b0; clear_err = 1'b0;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %b exp 1", overflow); else pass_cnt++;
        @(negedge clk); clear_err = 1'b1;
        @(negedge clk); clear_err = 1'b0;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", overflow); else pass_cnt++;
        op(1'b0, 1'b1, 8'h00);
        total_cnt++; if (sp !== 5'd15 || data_from_stack !== 8'h0E || full !== 1'b0)
            $display("FAIL pop_from_full got sp=%0d tos=%h full=%b exp sp=15 tos=0e full=0", sp, data_from_stack, full); else pass_cnt++;
    endtask

    task automatic test_replace();
        do_reset(2);
        op(1'b1, 1'b0, 8'h09);
        op(1'b1, 1'b0, 8'h05);
        op(1'b1, 1'b1, 8'h7E);
        total_cnt++; if (sp !== 5'd2 || data_from_stack !== 8'h7E)
            $display("FAIL replace got sp=%0d tos=%h exp sp=2 tos=7e", sp, data_from_stack); else pass_cnt++;
        op(1'b0, 1'b1, 8'h00);
        total_cnt++; if (sp !== 5'd1 || data_from_stack !== 8'h09)
            $display("FAIL replace_pop got sp=%0d tos=%h exp sp=1 tos=09", sp, data_from_stack); else pass_cnt++;
        op(1'b1, 1'b1, 8'h3C);
        op(1'b0, 1'b1, 8'h00);
        total_cnt++; if (sp !== 5'd0 || data_from_stack !== 8'h00)
            $display("FAIL replace_top_pop got sp=%0d tos=%h exp sp=0 tos=00", sp, data_from_stack); else pass_cnt++;
        op(1'b1, 1'b1, 8'h44);
        total_cnt++; if (sp !== 5'd1 || data_from_stack !== 8'h44 || overflow !== 1'b0 || underflow !== 1'b0)
            $display("FAIL replace_empty got sp=%0d tos=%h ovf=%b unf=%b exp sp=1 tos=44 ovf=0 unf=0", sp, data_from_stack, overflow, underflow); else pass_cnt++;
    endtask

    task automatic test_idle();
        op(1'b0, 1'b0, 8'hEE);
        total_cnt++; if (sp !== 5'd1 || data_from_stack !== 8'h44 || overflow !== 1'b0 || underflow !== 1'b0 || empty !== 1'b0 || full !== 1'b0)
            $display("FAIL idle_strobe got sp=%0d tos=%h flags=%b%b%b%b exp sp=1 tos=44 flags=0000", sp, data_from_stack, overflow, underflow, empty, full); else pass_cnt++;
        // Qualifiers changing while the strobe stays high do nothing.
        @(negedge clk); stack_clk = 1'b1;
        @(negedge clk); push = 1'b1; data_to_push = 8'h99;
        @(negedge clk); push = 1'b0; pop = 1'b1;
        @(negedge clk); pop = 1'b0; stack_clk = 1'b0;
        @(negedge clk);
        total_cnt++; if (sp !== 5'd1 || data_from_stack !== 8'h44)
            $display("FAIL no_trigger_ignored got sp=%0d tos=%h exp sp=1 tos=44", sp, data_from_stack); else pass_cnt++;
    endtask

    task automatic test_reset_strobe();
        @(negedge clk);
        reset = 1'b1; stack_clk = 1'b1; push = 1'b1; data_to_push = 8'h66;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (sp !== 5'd0 || data_from_stack !== 8'h00)
            $display("FAIL held_strobe_no_fire got sp=%0d tos=%h exp sp=0 tos=00", sp, data_from_stack); else pass_cnt++;
        stack_clk = 1'b0;
        @(negedge clk);
        stack_clk = 1'b1;
        @(negedge clk);
        total_cnt++; if (sp !== 5'd1 || data_from_stack !== 8'h66)
            $display("FAIL rearmed_push got sp=%0d tos=%h exp sp=1 tos=66", sp, data_from_stack); else pass_cnt++;
        stack_clk = 1'b0; push = 1'b0;
        @(negedge clk);
        // Reset coinciding with the trigger discards the push.
        stack_clk = 1'b1; push = 1'b1; data_to_push = 8'h77; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; stack_clk = 1'b0; push = 1'b0;
        total_cnt++; if (sp !== 5'd0 || data_from_stack !== 8'h00)
            $display("FAIL reset_on_trigger got sp=%0d tos=%h exp sp=0 tos=00", sp, data_from_stack); else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++; if (sp !== 5'd0 || empty !== 1'b1)
            $display("FAIL reset_on_trigger_late got sp=%0d empty=%b exp sp=0 empty=1", sp, empty); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_push();
        test_pop();
        test_full();
        test_replace();
        test_idle();
        test_reset_strobe();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
